conv_viterbi_dec: RTL and testbench



---
 rtl/conv_viterbi_dec.sv | 124 ++++++++++++
 tb/tb_conv_viterbi_dec.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_viterbi_dec.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) code, register-exchange survivors.
// Define VITERBI_ERRCNT_EN to add the err_cnt output (accumulated best-path bit errors).
module conv_viterbi_dec #(
   parameter int unsigned TB_DEPTH = 15,
   parameter int unsigned MW       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        in_valid,
   input  logic        v1,
   input  logic        v2,
   output logic        data_out,
`ifdef VITERBI_ERRCNT_EN
   output logic        out_valid,
   output logic [15:0] err_cnt
`else
   output logic        out_valid
`endif
);

   localparam int unsigned FW = $clog2(TB_DEPTH + 1);

   logic [MW-1:0]       pm        [4];
   logic [MW-1:0]       pm_raw    [4];
   logic [MW-1:0]       pm_norm   [4];
   logic [MW-1:0]       c0        [4];
   logic [MW-1:0]       c1        [4];
   logic [TB_DEPTH-1:0] surv      [4];
   logic [TB_DEPTH-1:0] surv_next [4];
   logic [MW-1:0]       pm_min;
   logic [1:0]          best;
   logic [FW-1:0]       fill;
   logic [1:0]          rx;

   assign rx = {v1, v2};

   // Hamming distance between the received pair and the pair emitted leaving pred on input u.
   function automatic logic [1:0] branch_metric(input logic [1:0] pred, input logic u,
                                                input logic [1:0] r);
      logic e1, e2;
      e1 = u ^ pred[1] ^ pred[0];
      e2 = u ^ pred[0];
      return {1'b0, r[1] ^ e1} + {1'b0, r[0] ^ e2};
   endfunction

   function automatic logic [MW-1:0] sat_add(input logic [MW-1:0] a, input logic [1:0] b);
      logic [MW:0] s;
      s = (MW+1)'(a) + (MW+1)'(b);
      return s[MW] ? '1 : s[MW-1:0];
   endfunction

   always_comb begin
      for (int unsigned ns = 0; ns < 4; ns++) begin
         c0[ns] = sat_add(pm[{ns[0], 1'b0}], branch_metric({ns[0], 1'b0}, ns[1], rx));
         c1[ns] = sat_add(pm[{ns[0], 1'b1}], branch_metric({ns[0], 1'b1}, ns[1], rx));
         // Ties resolve to the predecessor whose oldest bit is 0.
         if (c1[ns] < c0[ns]) begin
            pm_raw[ns]    = c1[ns];
            surv_next[ns] = {surv[{ns[0], 1'b1}][TB_DEPTH-2:0], ns[1]};
         end else begin
            pm_raw[ns]    = c0[ns];
            surv_next[ns] = {surv[{ns[0], 1'b0}][TB_DEPTH-2:0], ns[1]};
         end
      end
   end

   always_comb begin
      pm_min = pm_raw[0];
      best   = 2'd0;
      for (int unsigned i = 1; i < 4; i++) begin
         if (pm_raw[i] < pm_min) begin
            pm_min = pm_raw[i];
            best   = 2'(i);
         end
      end
      for (int unsigned i = 0; i < 4; i++) begin
         pm_norm[i] = pm_raw[i] - pm_min;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || load) begin
         pm[0] <= '0;
         pm[1] <= '1;
         pm[2] <= '1;
         pm[3] <= '1;
         for (int unsigned i = 0; i < 4; i++) begin
            surv[i] <= '0;
         end
         fill      <= '0;
         data_out  <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         for (int unsigned i = 0; i < 4; i++) begin
            pm[i]   <= pm_norm[i];
            surv[i] <= surv_next[i];
         end
         if (fill != FW'(TB_DEPTH)) begin
            fill <= fill + 1'b1;
         end
         // This symbol is number fill+1; a decision exists once that reaches TB_DEPTH.
         out_valid <= (fill >= FW'(TB_DEPTH - 1));
         data_out  <= surv_next[best][TB_DEPTH-1];
      end else begin
         out_valid <= 1'b0;
      end
   end

`ifdef VITERBI_ERRCNT_EN
   logic [16:0] err_sum;

   assign err_sum = 17'(err_cnt) + 17'(pm_min);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (!load && in_valid) begin
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end
`endif

endmodule

// File: tb/tb_conv_viterbi_dec.sv
// Directed, table-driven bench for conv_viterbi_dec (TB_DEPTH=15, MW=4).
// err_cnt checks are compiled in only when VITERBI_ERRCNT_EN is defined.
module tb_conv_viterbi_dec;

   localparam int unsigned TB_DEPTH = 15;
   localparam int unsigned NSYM     = 25;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic load = 1'b0;
   logic in_valid = 1'b0;
   logic v1 = 1'b0;
   logic v2 = 1'b0;
   logic data_out;
   logic out_valid;
`ifdef VITERBI_ERRCNT_EN
   logic [15:0] err_cnt;
`endif

   conv_viterbi_dec #(
      .TB_DEPTH (TB_DEPTH),
      .MW       (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .in_valid  (in_valid),
      .v1        (v1),
      .v2        (v2),
      .data_out  (data_out),
`ifdef VITERBI_ERRCNT_EN
      .out_valid (out_valid),
      .err_cnt   (err_cnt)
`else
      .out_valid (out_valid)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic       ld;
      logic [1:0] pair;
      logic       exp_ov;
      logic       exp_d;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;
   int   acc   = 0;
   logic last_d = 1'b0;

   // Data 1,0,1,0,0,0,1,1,1,0 then zeros; encoder tail flushed with zeros (first tail pair is 11).
   logic [1:0] clean_pairs [NSYM] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01,
                                      2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                      2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                      2'b00};
   logic       data_bits [NSYM] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [1:0] pairs [NSYM];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".ov"},   16'(out_valid), 16'h0);
      check({tag, ".d"},    16'(data_out),  16'h0);
      check({tag, ".pm0"},  16'(dut.pm[0]), 16'h0);
      check({tag, ".pm1"},  16'(dut.pm[1]), 16'hF);
      check({tag, ".pm2"},  16'(dut.pm[2]), 16'hF);
      check({tag, ".pm3"},  16'(dut.pm[3]), 16'hF);
      check({tag, ".fill"}, 16'(dut.fill),  16'h0);
   endtask

   task automatic push_sym(input logic [1:0] p);
      vec_t v;
      v.vld  = 1'b1;
      v.ld   = 1'b0;
      v.pair = p;
      acc++;
      if (acc >= int'(TB_DEPTH)) begin
         v.exp_ov = 1'b1;
         last_d   = data_bits[acc - int'(TB_DEPTH)];
      end else begin
         v.exp_ov = 1'b0;
      end
      v.exp_d = last_d;
      tbl.push_back(v);
   endtask

   task automatic push_idle(input int n);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.vld    = 1'b0;
         v.ld     = 1'b0;
         v.pair   = 2'b11;
         v.exp_ov = 1'b0;
         v.exp_d  = last_d;
         tbl.push_back(v);
      end
   endtask

   // A pair presented with load must be discarded.
   task automatic push_load(input logic [1:0] p);
      vec_t v;
      acc      = 0;
      last_d   = 1'b0;
      v.vld    = 1'b1;
      v.ld     = 1'b1;
      v.pair   = p;
      v.exp_ov = 1'b0;
      v.exp_d  = 1'b0;
      tbl.push_back(v);
   endtask

   task automatic push_stream(input int first, input int last, input bit gaps);
      for (int i = first; i <= last; i++) begin
         push_sym(pairs[i]);
         if (gaps && i < last) begin
            push_idle((i % 3) + 1);
         end
      end
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         in_valid   = tbl[i].vld;
         load       = tbl[i].ld;
         {v1, v2}   = tbl[i].pair;
         @(posedge clk);
         #1;
         check($sformatf("%s[%0d].ov", tag, i), 16'(out_valid), 16'(tbl[i].exp_ov));
         check($sformatf("%s[%0d].d", tag, i),  16'(data_out),  16'(tbl[i].exp_d));
      end
      in_valid = 1'b0;
      load     = 1'b0;
      tbl.delete();
   endtask

   task automatic do_reset(input string tag);
      reset    = 1'b1;
      load     = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      acc    = 0;
      last_d = 1'b0;
      check_reset_state(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // clean stream
      do_reset("rst_clean");
      pairs = clean_pairs;
      push_stream(0, NSYM - 1, 1'b0);
      run_tbl("clean");
`ifdef VITERBI_ERRCNT_EN
      check("clean.err_cnt", err_cnt, 16'd0);
`endif

      // single bit error in pair 3
      do_reset("rst_err1");
      pairs    = clean_pairs;
      pairs[2] = 2'b01;
      push_stream(0, NSYM - 1, 1'b0);
      run_tbl("err1");
`ifdef VITERBI_ERRCNT_EN
      check("err1.err_cnt", err_cnt, 16'd1);
`endif

      // two spaced errors in pairs 2 and 9
      do_reset("rst_err2");
      pairs    = clean_pairs;
      pairs[1] = 2'b11;
      pairs[8] = 2'b11;
      push_stream(0, NSYM - 1, 1'b0);
      run_tbl("err2");
`ifdef VITERBI_ERRCNT_EN
      check("err2.err_cnt", err_cnt, 16'd2);
`endif

      // gaps of 1..3 idle cycles between pairs
      do_reset("rst_gap");
      pairs = clean_pairs;
      push_stream(0, NSYM - 1, 1'b1);
      run_tbl("gap");

      // load after pair 6, then the full stream again
      do_reset("rst_load");
      pairs = clean_pairs;
      push_stream(0, 5, 1'b0);
      push_load(2'b11);
      push_stream(0, NSYM - 1, 1'b0);
      run_tbl("load");

      // reset with load and a valid pair while a decision is held on data_out
      do_reset("rst_prio");
      pairs = clean_pairs;
      push_stream(0, int'(TB_DEPTH) - 1, 1'b0);
      run_tbl("prio_pre");
      check("prio_pre.held_d", 16'(data_out), 16'h1);
      reset    = 1'b1;
      load     = 1'b1;
      in_valid = 1'b1;
      {v1, v2} = 2'b11;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      load     = 1'b0;
      in_valid = 1'b0;
      acc      = 0;
      last_d   = 1'b0;
      check_reset_state("prio");
`ifdef VITERBI_ERRCNT_EN
      check("prio.err_cnt", err_cnt, 16'd0);
`endif
      push_stream(0, NSYM - 1, 1'b0);
      run_tbl("prio_post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
